// File: rtl/reg_writer.sv
// reg_writer: Y86 register file write side with dual write-back ports, per-register clear and a pending-write scoreboard.
module reg_writer #(
    parameter logic [31:0] SP_INIT  = 32'h0000_0000,
    parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  clr,
    input  logic        wE_en,
    input  logic [2:0]  wE_dst,
    input  logic [31:0] wE_val,
    input  logic        wM_en,
    input  logic [2:0]  wM_dst,
    input  logic [31:0] wM_val,
    input  logic        claim_en,
    input  logic [2:0]  claim_dst,
    output logic [31:0] Q_0,
    output logic [31:0] Q_1,
    output logic [31:0] Q_2,
    output logic [31:0] Q_3,
    output logic [31:0] Q_4,
    output logic [31:0] Q_5,
    output logic [31:0] Q_6,
    output logic [31:0] Q_7,
    output logic [7:0]  pending,
    output logic        wr_conflict
);
    logic [31:0] q [8];

    for (genvar i = 0; i < 8; i++) begin : g_reg
        localparam logic [2:0]  idx  = 3'(i);
        localparam logic [31:0] init = (i == 4) ? SP_INIT : REG_INIT;
        logic e_hit, m_hit;
        assign e_hit = wE_en && wE_dst == idx;
        assign m_hit = wM_en && wM_dst == idx;
        // M beats E on a shared destination so popl %esp lands the popped value
        always_ff @(posedge clk) begin
            if (!reset_n || clr[i]) q[i] <= init;
            else if (m_hit) q[i] <= wM_val;
            else if (e_hit) q[i] <= wE_val;
        end
        // a same-cycle claim belongs to the younger instruction, so it outranks the commit
        always_ff @(posedge clk) begin
            if (!reset_n || clr[i]) pending[i] <= 1'b0;
            else if (claim_en && claim_dst == idx) pending[i] <= 1'b1;
            else if (e_hit || m_hit) pending[i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) wr_conflict <= 1'b0;
        else wr_conflict <= wE_en && wM_en && wE_dst == wM_dst;
    end

    assign Q_0 = q[0];
    assign Q_1 = q[1];
    assign Q_2 = q[2];
    assign Q_3 = q[3];
    assign Q_4 = q[4];
    assign Q_5 = q[5];
    assign Q_6 = q[6];
    assign Q_7 = q[7];
endmodule

// File: tb/tb_reg_writer.sv
// tb_reg_writer: directed plus random stimulus against a write-ordering reference model, scoreboard-checked every cycle.
module tb_reg_writer;
    localparam logic [31:0] SP = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  clr = '0;
    logic        wE_en = 1'b0, wM_en = 1'b0, claim_en = 1'b0;
    logic [2:0]  wE_dst = '0, wM_dst = '0, claim_dst = '0;
    logic [31:0] wE_val = '0, wM_val = '0;
    logic [31:0] q_out [8];
    logic [7:0]  pending;
    logic        wr_conflict;

    reg_writer #(.SP_INIT(SP), .REG_INIT(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .wE_en(wE_en), .wE_dst(wE_dst), .wE_val(wE_val),
        .wM_en(wM_en), .wM_dst(wM_dst), .wM_val(wM_val),
        .claim_en(claim_en), .claim_dst(claim_dst),
        .Q_0(q_out[0]), .Q_1(q_out[1]), .Q_2(q_out[2]), .Q_3(q_out[3]),
        .Q_4(q_out[4]), .Q_5(q_out[5]), .Q_6(q_out[6]), .Q_7(q_out[7]),
        .pending(pending), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] q;
        logic [7:0]       p;
        logic             c;
    } exp_t;

    exp_t        sb [$];
    exp_t        model;
    int          checks = 0;
    int          passes = 0;

    function automatic logic [31:0] init_of(int i);
        return (i == 4) ? SP : 32'h0;
    endfunction

    // Model: apply E then M in program order (later write overwrites), set claim after commits, then clear/reset wipe.
    task automatic step(input logic rn, input logic [7:0] cl,
                        input logic ee, input logic [2:0] ed, input logic [31:0] ev,
                        input logic me, input logic [2:0] md, input logic [31:0] mv,
                        input logic ce, input logic [2:0] cd);
        exp_t n;
        @(negedge clk);
        reset_n = rn; clr = cl;
        wE_en = ee; wE_dst = ed; wE_val = ev;
        wM_en = me; wM_dst = md; wM_val = mv;
        claim_en = ce; claim_dst = cd;
        n = model;
        n.c = ee && me && (ed == md);
        if (ee) begin n.q[ed] = ev; n.p[ed] = 1'b0; end
        if (me) begin n.q[md] = mv; n.p[md] = 1'b0; end
        if (ce) n.p[cd] = 1'b1;
        for (int i = 0; i < 8; i++)
            if (!rn || cl[i]) begin n.q[i] = init_of(i); n.p[i] = 1'b0; end
        if (!rn) n.c = 1'b0;
        model = n;
        sb.push_back(n);
    endtask

    task automatic idle();
        step(1'b1, 8'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (q_out[i] === e.q[i]) passes++;
                    else $display("FAIL Q_%0d at %0t: got %h expected %h", i, $time, q_out[i], e.q[i]);
                end
                checks++;
                if (pending === e.p) passes++;
                else $display("FAIL pending at %0t: got %h expected %h", $time, pending, e.p);
                checks++;
                if (wr_conflict === e.c) passes++;
                else $display("FAIL wr_conflict at %0t: got %b expected %b", $time, wr_conflict, e.c);
            end
        end
    end

    initial begin : stim
        model = '0;
        step(1'b0, 8'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        step(1'b0, 8'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
        step(1'b1, 8'h0, 1'b1, 3'd1, 32'hDEAD_BEEF, 1'b1, 3'd2, 32'h1234_5678, 1'b0, 3'd0);
        idle();
        step(1'b1, 8'h0, 1'b1, 3'd4, 32'h10, 1'b1, 3'd4, 32'h20, 1'b0, 3'd0);
        idle();
        idle();
        step(1'b1, 8'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3);
        idle();
        step(1'b1, 8'h0, 1'b1, 3'd3, 32'hAAAA_0003, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3);
        step(1'b1, 8'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 32'hBBBB_0003, 1'b0, 3'd0);
        step(1'b1, 8'h02, 1'b1, 3'd5, 32'h7, 1'b1, 3'd1, 32'hFFFF_FFFF, 1'b0, 3'd0);
        idle();
        step(1'b0, 8'h0, 1'b1, 3'd2, 32'hAA, 1'b1, 3'd6, 32'hBB, 1'b1, 3'd1);
        idle();
        step(1'b1, 8'h0, 1'b1, 3'd7, 32'h77, 1'b1, 3'd0, 32'h11, 1'b1, 3'd6);
        step(1'b1, 8'hFF, 1'b1, 3'd2, 32'h5, 1'b1, 3'd2, 32'h6, 1'b1, 3'd2);
        idle();
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 39) != 0,
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0,
                 1'($urandom), 3'($urandom), $urandom,
                 1'($urandom), 3'($urandom), $urandom,
                 1'($urandom), 3'($urandom));
        idle();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/reg_writer.md
# reg_writer

Write side of the Y86 register file. Holds the eight 32-bit program registers, commits up to two write-back results per cycle (execute port E, memory port M), and drives the `Q_0`..`Q_7` buses that the register read muxes select from. It also keeps a per-register pending scoreboard, so decode can detect read-after-write hazards, and it honours the 8-bit per-register `clr` vector produced by the read side.

## Interface
Parameters:
- `SP_INIT`, default `32'h0000_0000`: reset and clear value of register 4 (`%esp`).
- `REG_INIT`, default `32'h0000_0000`: reset and clear value of every other register.

Ports:
- `clk`  input  1: the only clock; all state changes on the rising edge.
- `reset_n`  input  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `clr`  input  8: per-register synchronous clear; bit i clears register i.
- `wE_en`  input  1: port E write enable.
- `wE_dst`  input  3: port E destination register.
- `wE_val`  input  32: port E data (valE).
- `wM_en`  input  1: port M write enable.
- `wM_dst`  input  3: port M destination register.
- `wM_val`  input  32: port M data (valM).
- `claim_en`  input  1: decode issued an instruction that will write `claim_dst`.
- `claim_dst`  input  3: register being claimed.
- `Q_0`..`Q_7`  output  32 each: current register contents.
- `pending`  output  8: bit i set means a claimed write to register i has not yet committed.
- `wr_conflict`  output  1: registered flag; pulses when E and M targeted the same register in the previous cycle.

## Operation
- Storage: 8 × 32-bit flops. `Q_i` is driven directly from flop i, with no read-time bypass.
- Per-register next-state priority, highest first:
  - `reset_n`=0 → init value;
  - `clr[i]`=1 → init value;
  - M hit → `wM_val`;
  - E hit → `wE_val`;
  - otherwise hold.
- "Hit" means `wX_en`=1 and `wX_dst`=i.
- E and M to different registers in the same cycle: both commit.
- E and M to the same register: M wins (Y86 `popl %esp` rule). E is dropped, and `wr_conflict` goes to 1 on the next cycle for one cycle.
- Scoreboard, bit i next-state priority:
  - reset or `clr[i]` → 0;
  - claim of i → 1;
  - any write hit on i → 0;
  - otherwise hold.
- Claim and write to the same register in the same cycle: the pending bit stays 1, because the claim is the younger instruction.
- Single-bit pending only. A second claim before the first commits is legal; the first write clears the bit. Decode must stall on `pending` to avoid this case.
- No arithmetic; the 32-bit data passes through unmodified.

## Timing
- Write latency is 1 cycle: data presented at edge N is visible on `Q_i` after edge N.
- A read in the same cycle as a write returns the old value. Forwarding is the pipeline's job.
- `pending` and `wr_conflict` are registered and update at the same edge as the data.
- Reset values:
  - `Q_4` = `SP_INIT`;
  - other `Q_i` = `REG_INIT`;
  - `pending` = 0;
  - `wr_conflict` = 0.
- Reset mid-operation: writes, claims and `clr` presented in a cycle with `reset_n`=0 are discarded entirely. The first accepted write is the one on the first edge with `reset_n`=1.
- `clr` presented together with a write to the same register: the clear wins and the write is lost. Writes to other registers in that cycle still commit.
- `clr`=8'hFF with `reset_n`=1 is equivalent to reset for the registers and `pending`. `wr_conflict` still reflects the cycle's E/M collision.
- No handshake back-pressure: every enabled write is accepted every cycle.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with `SP_INIT`=32'h0000_1000 → `Q_4`=32'h1000, all other Q=0, `pending`=8'h00, `wr_conflict`=0.
- Dual write: E writes reg 1 with 32'hDEAD_BEEF and M writes reg 2 with 32'h1234_5678 at the same edge → both visible next cycle, with the old values visible in the cycle they are presented.
- Collision: E writes reg 4 with 32'h10 and M writes reg 4 with 32'h20 → `Q_4`=32'h20 and `wr_conflict`=1 for exactly one cycle.
- Scoreboard:
  - claim reg 3 → `pending`=8'h08;
  - two cycles later, claim reg 3 and E write reg 3 in the same cycle → `pending` stays 8'h08;
  - next cycle, M write reg 3 → `pending`=8'h00.
- Clear priority: `clr`=8'h02 with M writing reg 1 (32'hFFFF_FFFF) and E writing reg 5 (32'h7) → `Q_1`=0 and `Q_5`=7.
- Reset mid-operation: assert `reset_n`=0 in the same cycle as writes and a claim → all writes and the claim are discarded and every output returns to its reset value.
